m_unit_arbiter: RTL and testbench
=================================

Name: m_unit_arbiter

Overview:
- Shares one M-extension PCPI coprocessor between N_REQ PCPI requesters, e.g. a core plus a benchmark traffic generator, or two cores.
- Filters requests for M-class instructions, grants them round-robin, and holds the coprocessor operands stable for the whole operation.
- Routes the result back to the granted requester. Inserts the one-cycle release gap the coprocessor needs between operations.
- Provides a watchdog so a hung operation cannot stall the requesters forever.

Parameters:
N_REQ, 2, number of requesters (2..8)
TIMEOUT_CYCLES, 64, max BUSY cycles without m_ready before abort
ID_W, $clog2(N_REQ) (min 1), grant index width

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-high (asserted = 1)
req_valid  in  N_REQ  per-requester PCPI valid
req_insn  in  N_REQ*32  per-requester instruction, slice i = [32i+31:32i]
req_rs1  in  N_REQ*32  per-requester operand 1
req_rs2  in  N_REQ*32  per-requester operand 2
req_ready  out  N_REQ  per-requester completion pulse
req_wr  out  N_REQ  per-requester write-back enable
req_rd  out  32  result, shared bus, qualified by req_ready
req_busy  out  N_REQ  per-requester busy
m_valid  out  1  coprocessor valid
m_insn  out  32  coprocessor instruction
m_rs1  out  32  coprocessor operand 1
m_rs2  out  32  coprocessor operand 2
m_ready  in  1  coprocessor completion
m_wr  in  1  coprocessor write-back enable
m_rd  in  32  coprocessor result
m_busy  in  1  coprocessor busy
grant_id  out  ID_W  index of current/last granted requester
timeout_err  out  1  sticky flag: a watchdog abort occurred

Behaviour:
- Eligible request i: req_valid[i] & opcode == 7'b0110011 & funct7 == 7'b0000001. Non-eligible requests are never granted and never answered.
- Reset, asynchronous, any state: state = IDLE, rr_ptr = 0, grant_id = 0, timeout counter = 0, captured insn/rs1/rs2 = 0, timeout_err = 0.
  - All outputs are 0 during reset.
  - Reset mid-operation abandons the operation with no response.
- State IDLE:
  - m_valid = 0.
  - If any request is eligible, pick the first eligible index at or after rr_ptr, wrapping modulo N_REQ.
  - Register grant_id and capture that requester's insn/rs1/rs2, then go to BUSY.
  - Request-to-m_valid latency is 1 cycle.
- State BUSY:
  - m_valid = 1. m_insn/m_rs1/m_rs2 come from the captured registers, stable for the whole operation.
  - Counter increments each cycle.
  - On m_ready: req_ready[grant] = 1, req_wr[grant] = m_wr, req_rd = m_rd, all combinational in the same cycle. Then rr_ptr = grant + 1 (mod N_REQ), go to RELEASE.
  - If the counter reaches TIMEOUT_CYCLES without m_ready, abort:
    - req_ready[grant] = 1, req_wr = 0, req_rd = 0.
    - Set timeout_err.
    - Advance rr_ptr, go to DRAIN.
- State DRAIN:
  - m_valid = 0, operands held.
  - Wait for m_ready; the late result is discarded and produces no req_ready. Then go to RELEASE.
- State RELEASE:
  - One cycle with m_valid = 0, so the coprocessor returns to idle and the served requester drops valid.
  - Go to IDLE.
  - Minimum spacing is 1 gap cycle between an m_ready and the next m_valid.
- req_busy[i] = eligible(i) & ~req_ready[i].
  - Waiting requesters therefore see busy and do not hit their own PCPI timeout.
  - req_busy for non-eligible requests = 0.
- req_ready/req_wr are single-cycle pulses. req_rd = 0 whenever no req_ready is asserted.
- A requester that drops valid mid-operation does not cancel it. The operation completes and the response pulse is still issued.
- The counter resets on entry to BUSY. Its width is $clog2(TIMEOUT_CYCLES+1).
- timeout_err is cleared only by reset.

Test Plan:
1. Req0 MUL, rs1 = 7, rs2 = 6, with the real M unit:
   - m_valid rises 1 cycle after req_valid.
   - req_ready[0] = 1, req_wr[0] = 1, req_rd = 42.
   - req_ready[1] stays 0.
2. Req0 and req1 both issue DIVU 100/7 in the same cycle, rr_ptr = 0:
   - req0 is served first with rd = 14.
   - A RELEASE gap cycle follows, then req1 is served with rd = 14.
   - A repeat of both → req1 first (ptr advanced).
   - req_busy[1] = 1 throughout req0's operation.
3. Req1 issues ADD (funct7 = 0):
   - m_valid never rises, req_busy[1] = 0, no req_ready.
   - A concurrent req0 REM -7 % 3 is served normally with rd = 0xFFFFFFFF.
4. Stub M unit asserts m_busy but withholds m_ready for 100 cycles:
   - At BUSY cycle 64: req_ready[0] = 1, req_wr = 0, timeout_err = 1.
   - The stub's late m_ready is swallowed.
   - Next grant goes to req1.
5. Reset asserted mid-DIV (BUSY, cycle 10):
   - All outputs are 0 immediately, asynchronously.
   - After release, a new MULHU 0xFFFFFFFF × 2 → rd = 1.
6. Req0 holds valid with back-to-back MULs (changes insn/rs after each ready):
   - Exactly one m_valid = 0 cycle between operations.
   - m_rs1/m_rs2 never change while m_valid = 1.

Source files
------------

// File: rtl/m_unit_arbiter.sv
// Shares one PCPI M-extension unit between N_REQ requesters: filters M-class requests,
// grants them round-robin, holds operands stable, and aborts hung operations via a watchdog.
module m_unit_arbiter #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ID_W           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*32-1:0]   req_insn,
  input  logic [N_REQ*32-1:0]   req_rs1,
  input  logic [N_REQ*32-1:0]   req_rs2,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      req_wr,
  output logic [31:0]           req_rd,
  output logic [N_REQ-1:0]      req_busy,
  output logic                  m_valid,
  output logic [31:0]           m_insn,
  output logic [31:0]           m_rs1,
  output logic [31:0]           m_rs2,
  input  logic                  m_ready,
  input  logic                  m_wr,
  input  logic [31:0]           m_rd,
  input  logic                  m_busy,
  output logic [ID_W-1:0]       grant_id,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_RELEASE} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       insn_q, insn_d;
  logic [31:0]       rs1_q, rs1_d;
  logic [31:0]       rs2_q, rs2_d;
  logic              terr_q, terr_d;

  logic [N_REQ-1:0]  elig;
  logic [ID_W-1:0]   cand_idx [N_REQ];
  logic [N_REQ-1:0]  cand_elig;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic [ID_W-1:0]   grant_next;
  logic              tmo;
  logic              result_ok;
  logic              resp_fire;
  logic              unused_m_busy;

  // cand_idx[k] is the k-th requester in round-robin order starting at rr_ptr_q
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      logic [ID_W:0] sum;
      assign elig[gi] = req_valid[gi]
                        && (req_insn[32*gi +: 7] == 7'b0110011)
                        && (req_insn[32*gi+25 +: 7] == 7'b0000001);
      assign sum = {1'b0, rr_ptr_q} + (ID_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ))
                                                       : sum[ID_W-1:0];
      assign cand_elig[gi] = elig[cand_idx[gi]];
      assign req_ready[gi] = resp_fire && (grant_q == ID_W'(gi));
      assign req_wr[gi]    = result_ok && m_wr && (grant_q == ID_W'(gi));
      assign req_busy[gi]  = !resetn && elig[gi] && !req_ready[gi];
    end
  endgenerate

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_elig[k]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  assign grant_next = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign tmo = (state_q == S_BUSY) && !m_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      insn_q   <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      insn_q   <= insn_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      terr_q   <= terr_d;
    end
  end

  // RELEASE arbitrates like IDLE, so the gap after a completion is exactly one cycle
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    insn_d   = insn_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    terr_d   = terr_q;
    case (state_q)
      S_IDLE, S_RELEASE: begin
        state_d = S_IDLE;
        if (pick_found) begin
          state_d = S_BUSY;
          grant_d = pick_idx;
          insn_d  = req_insn[{pick_idx, 5'b0} +: 32];
          rs1_d   = req_rs1[{pick_idx, 5'b0} +: 32];
          rs2_d   = req_rs2[{pick_idx, 5'b0} +: 32];
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (m_ready) begin
          rr_ptr_d = grant_next;
          state_d  = S_RELEASE;
        end else if (tmo) begin
          rr_ptr_d = grant_next;
          terr_d   = 1'b1;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (m_ready) state_d = S_RELEASE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_valid   = (state_q == S_BUSY);
    result_ok = m_valid && m_ready;
    resp_fire = result_ok || tmo;
    req_rd    = result_ok ? m_rd : 32'd0;
  end

  assign m_insn        = insn_q;
  assign m_rs1         = rs1_q;
  assign m_rs2         = rs2_q;
  assign grant_id      = grant_q;
  assign timeout_err   = terr_q;
  assign unused_m_busy = m_busy;

endmodule

// File: tb/tb_m_unit_arbiter.sv
// Bench for m_unit_arbiter: behavioural M unit (normal and hung-stub modes) and a
// response scoreboard; expected results are queued when each request is driven.
`timescale 1ns/1ps
module tb_m_unit_arbiter;
  localparam int N_REQ = 2;
  localparam int ID_W  = 1;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ*32-1:0] req_insn = '0;
  logic [N_REQ*32-1:0] req_rs1 = '0;
  logic [N_REQ*32-1:0] req_rs2 = '0;
  logic [N_REQ-1:0]    req_ready, req_wr, req_busy;
  logic [31:0]         req_rd;
  logic                m_valid;
  logic [31:0]         m_insn, m_rs1, m_rs2;
  logic                m_ready, m_wr, m_busy;
  logic [31:0]         m_rd;
  logic [ID_W-1:0]     grant_id;
  logic                timeout_err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {int idx; logic wr; logic [31:0] rd;} exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  m_unit_arbiter #(.N_REQ(N_REQ), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_ready(req_ready), .req_wr(req_wr), .req_rd(req_rd), .req_busy(req_busy),
    .m_valid(m_valid), .m_insn(m_insn), .m_rs1(m_rs1), .m_rs2(m_rs2),
    .m_ready(m_ready), .m_wr(m_wr), .m_rd(m_rd), .m_busy(m_busy),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    mk = {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input int i);
    onehot = N_REQ'(1) << i;
  endfunction

  function automatic logic [31:0] mcalc(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ss, su, uu;
    logic signed [31:0] sa, sb;
    logic ovf;
    sa = a; sb = b;
    ss = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    su = {{32{a[31]}}, a} * {32'd0, b};
    uu = {32'd0, a} * {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (insn[14:12])
      3'd0: mcalc = ss[31:0];
      3'd1: mcalc = ss[63:32];
      3'd2: mcalc = su[63:32];
      3'd3: mcalc = uu[63:32];
      3'd4: mcalc = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: mcalc = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: mcalc = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: mcalc = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Behavioural coprocessor: normal mode answers lat cycles after m_valid; stub mode
  // raises m_busy and answers stub_delay cycles later regardless of m_valid.
  int lat = 3;
  bit stub_mode = 1'b0;
  int stub_delay = 100;
  int stub_cnt;
  bit stub_run;
  int mcnt;

  always @(posedge clk or posedge resetn) begin
    if (resetn) begin
      m_ready <= 1'b0; m_wr <= 1'b0; m_rd <= '0; m_busy <= 1'b0;
      mcnt <= 0; stub_run <= 1'b0; stub_cnt <= 0;
    end else begin
      m_ready <= 1'b0; m_wr <= 1'b0; m_rd <= '0;
      if (stub_mode) begin
        if (!stub_run) begin
          if (m_valid) begin stub_run <= 1'b1; stub_cnt <= 1; m_busy <= 1'b1; end
        end else if (stub_cnt == stub_delay - 1) begin
          m_ready <= 1'b1; m_wr <= 1'b1; m_rd <= 32'hDEAD_BEEF;
          stub_run <= 1'b0; m_busy <= 1'b0;
        end else begin
          stub_cnt <= stub_cnt + 1;
        end
      end else begin
        m_busy <= 1'b0;
        if (m_valid && !m_ready) begin
          if (mcnt >= lat - 1) begin
            m_ready <= 1'b1; m_wr <= 1'b1; m_rd <= mcalc(m_insn, m_rs1, m_rs2); mcnt <= 0;
          end else begin
            mcnt <= mcnt + 1; m_busy <= 1'b1;
          end
        end else begin
          mcnt <= 0;
        end
      end
    end
  end

  task automatic set_req(input int i, input bit v, input logic [31:0] insn,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]        = v;
    req_insn[32*i +: 32] = insn;
    req_rs1[32*i +: 32]  = a;
    req_rs2[32*i +: 32]  = b;
  endtask

  task automatic wait_resp(input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin got = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 resetn = 1'b1;
    set_req(0, 1'b1, mk(7'h01, 3'd0), 32'd3, 32'd4);
    repeat (2) @(negedge clk);
    n_vec++;
    if ({m_valid, req_ready, req_wr, req_busy, timeout_err} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: valid=%b ready=%b wr=%b busy=%b terr=%b, required all 0",
               m_valid, req_ready, req_wr, req_busy, timeout_err);
    end
    n_vec++;
    if ({req_rd, m_insn, m_rs1, m_rs2, grant_id} !== '0) begin
      n_err++;
      $display("FAIL reset_data: rd=%h insn=%h rs1=%h rs2=%h grant=%0d, required all 0",
               req_rd, m_insn, m_rs1, m_rs2, grant_id);
    end
    set_req(0, 1'b0, '0, '0, '0);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (m_valid !== 1'b0 || req_ready !== '0) begin
      n_err++;
      $display("FAIL idle_after_reset: valid=%b ready=%b, required 0 0", m_valid, req_ready);
    end
  endtask

  task automatic test_mul();
    exp_t e;
    bit got;
    set_req(0, 1'b1, mk(7'h01, 3'd0), 32'd7, 32'd6);
    exp_q.push_back('{0, 1'b1, 32'd42});
    #1;
    n_vec++;
    if (m_valid !== 1'b0) begin
      n_err++; $display("FAIL mul_pre_valid: m_valid=%b, required 0", m_valid);
    end
    @(negedge clk);
    n_vec++;
    if (m_valid !== 1'b1 || m_rs1 !== 32'd7 || m_rs2 !== 32'd6 || grant_id !== 1'b0) begin
      n_err++;
      $display("FAIL mul_latency: valid=%b rs1=%0d rs2=%0d grant=%0d, required 1 7 6 0",
               m_valid, m_rs1, m_rs2, grant_id);
    end
    wait_resp(20, got);
    set_req(0, 1'b0, '0, '0, '0);
    e = exp_q.pop_front();
    n_vec++;
    if (!got || req_ready !== onehot(e.idx) || req_wr !== (e.wr ? onehot(e.idx) : '0) || req_rd !== e.rd) begin
      n_err++;
      $display("FAIL mul_resp: got=%b ready=%b wr=%b rd=%h, required ready=%b wr=%b rd=%h",
               got, req_ready, req_wr, req_rd, onehot(e.idx), e.wr ? onehot(e.idx) : '0, e.rd);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    exp_t e;
    bit got;
    do_reset();
    set_req(0, 1'b1, mk(7'h01, 3'd5), 32'd100, 32'd7);
    set_req(1, 1'b1, mk(7'h01, 3'd5), 32'd100, 32'd7);
    exp_q.push_back('{0, 1'b1, 32'd14});
    exp_q.push_back('{1, 1'b1, 32'd14});
    got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin got = 1'b1; break; end
      n_vec++;
      if (req_busy !== 2'b11) begin
        n_err++; $display("FAIL rr_busy_wait: busy=%b, required 11", req_busy);
      end
    end
    e = exp_q.pop_front();
    n_vec++;
    if (!got || req_ready !== onehot(e.idx) || req_wr !== onehot(e.idx) || req_rd !== e.rd || req_busy !== 2'b10) begin
      n_err++;
      $display("FAIL rr_first: got=%b ready=%b wr=%b rd=%h busy=%b, required ready=%b rd=%h busy=10",
               got, req_ready, req_wr, req_rd, req_busy, onehot(e.idx), e.rd);
    end
    set_req(0, 1'b0, '0, '0, '0);
    @(negedge clk);
    n_vec++;
    if (m_valid !== 1'b0) begin
      n_err++; $display("FAIL rr_gap: m_valid=%b, required 0", m_valid);
    end
    @(negedge clk);
    n_vec++;
    if (m_valid !== 1'b1 || grant_id !== 1'b1) begin
      n_err++; $display("FAIL rr_second_grant: valid=%b grant=%0d, required 1 1", m_valid, grant_id);
    end
    wait_resp(20, got);
    set_req(1, 1'b0, '0, '0, '0);
    e = exp_q.pop_front();
    n_vec++;
    if (!got || req_ready !== onehot(e.idx) || req_wr !== onehot(e.idx) || req_rd !== e.rd) begin
      n_err++;
      $display("FAIL rr_second: got=%b ready=%b wr=%b rd=%h, required ready=%b rd=%h",
               got, req_ready, req_wr, req_rd, onehot(e.idx), e.rd);
    end
    // a lone req0 leaves the pointer at req1, so the next contested round favours req1
    @(negedge clk);
    set_req(0, 1'b1, mk(7'h01, 3'd5), 32'd100, 32'd7);
    exp_q.push_back('{0, 1'b1, 32'd14});
    wait_resp(20, got);
    set_req(0, 1'b0, '0, '0, '0);
    e = exp_q.pop_front();
    n_vec++;
    if (!got || req_ready !== onehot(e.idx) || req_rd !== e.rd) begin
      n_err++;
      $display("FAIL rr_solo: got=%b ready=%b rd=%h, required ready=%b rd=%h",
               got, req_ready, req_rd, onehot(e.idx), e.rd);
    end
    @(negedge clk);
    set_req(0, 1'b1, mk(7'h01, 3'd0), 32'd3, 32'd5);
    set_req(1, 1'b1, mk(7'h01, 3'd0), 32'd4, 32'd5);
    exp_q.push_back('{1, 1'b1, 32'd20});
    exp_q.push_back('{0, 1'b1, 32'd15});
    for (int r = 0; r < 2; r++) begin
      wait_resp(20, got);
      e = exp_q.pop_front();
      set_req(e.idx, 1'b0, '0, '0, '0);
      n_vec++;
      if (!got || req_ready !== onehot(e.idx) || req_rd !== e.rd) begin
        n_err++;
        $display("FAIL rr_repeat%0d: got=%b ready=%b rd=%h, required ready=%b rd=%h",
                 r, got, req_ready, req_rd, onehot(e.idx), e.rd);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_filter();
    exp_t e;
    bit got;
    set_req(1, 1'b1, mk(7'h00, 3'd0), 32'd1, 32'd2);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_vec++;
      if (m_valid !== 1'b0 || req_busy !== '0 || req_ready !== '0) begin
        n_err++;
        $display("FAIL filter_add: valid=%b busy=%b ready=%b, required 0 00 00", m_valid, req_busy, req_ready);
      end
    end
    set_req(0, 1'b1, mk(7'h01, 3'd6), 32'hFFFF_FFF9, 32'd3);
    exp_q.push_back('{0, 1'b1, 32'hFFFF_FFFF});
    got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_vec++;
      if (req_busy[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
        n_err++;
        $display("FAIL filter_req1: busy1=%b ready1=%b, required 0 0", req_busy[1], req_ready[1]);
      end
      if (req_ready != '0) begin got = 1'b1; break; end
    end
    e = exp_q.pop_front();
    n_vec++;
    if (!got || req_ready !== onehot(e.idx) || req_wr !== onehot(e.idx) || req_rd !== e.rd) begin
      n_err++;
      $display("FAIL filter_rem: got=%b ready=%b wr=%b rd=%h, required ready=%b rd=%h",
               got, req_ready, req_wr, req_rd, onehot(e.idx), e.rd);
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_timeout();
    exp_t e;
    bit got;
    int k;
    stub_mode = 1'b1;
    set_req(0, 1'b1, mk(7'h01, 3'd0), 32'd9, 32'd9);
    exp_q.push_back('{0, 1'b0, 32'd0});
    k = 0;
    got = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      k = c;
      if (req_ready != '0) begin got = 1'b1; break; end
    end
    e = exp_q.pop_front();
    n_vec++;
    if (!got || k != 64 || req_ready !== onehot(e.idx) || req_wr !== '0 || req_rd !== e.rd) begin
      n_err++;
      $display("FAIL tmo_abort: got=%b cycle=%0d ready=%b wr=%b rd=%h, required cycle=64 ready=%b wr=00 rd=%h",
               got, k, req_ready, req_wr, req_rd, onehot(e.idx), e.rd);
    end
    set_req(0, 1'b0, '0, '0, '0);
    @(negedge clk);
    n_vec++;
    if (timeout_err !== 1'b1 || m_valid !== 1'b0) begin
      n_err++; $display("FAIL tmo_flag: terr=%b valid=%b, required 1 0", timeout_err, m_valid);
    end
    set_req(0, 1'b1, mk(7'h01, 3'd0), 32'd2, 32'd3);
    set_req(1, 1'b1, mk(7'h01, 3'd0), 32'd5, 32'd5);
    got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      n_vec++;
      if (req_ready !== '0 || m_valid !== 1'b0) begin
        n_err++; $display("FAIL tmo_drain: ready=%b valid=%b, required 00 0", req_ready, m_valid);
      end
      if (m_ready) begin got = 1'b1; break; end
    end
    stub_mode = 1'b0;
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL tmo_late_ready: late m_ready seen=%b, required 1", got);
    end
    exp_q.push_back('{1, 1'b1, 32'd25});
    exp_q.push_back('{0, 1'b1, 32'd6});
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (m_valid !== 1'b1 || grant_id !== 1'b1) begin
      n_err++; $display("FAIL tmo_next_grant: valid=%b grant=%0d, required 1 1", m_valid, grant_id);
    end
    for (int r = 0; r < 2; r++) begin
      wait_resp(20, got);
      e = exp_q.pop_front();
      set_req(e.idx, 1'b0, '0, '0, '0);
      n_vec++;
      if (!got || req_ready !== onehot(e.idx) || req_wr !== onehot(e.idx) || req_rd !== e.rd) begin
        n_err++;
        $display("FAIL tmo_after%0d: got=%b ready=%b rd=%h, required ready=%b rd=%h",
                 r, got, req_ready, req_rd, onehot(e.idx), e.rd);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    bit got;
    n_vec++;
    if (timeout_err !== 1'b1) begin
      n_err++; $display("FAIL terr_sticky: terr=%b, required 1", timeout_err);
    end
    lat = 40;
    set_req(0, 1'b1, mk(7'h01, 3'd4), 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    resetn = 1'b1;
    #1;
    n_vec++;
    if ({m_valid, req_ready, req_wr, req_busy, timeout_err, grant_id} !== '0
        || {req_rd, m_insn, m_rs1, m_rs2} !== '0) begin
      n_err++;
      $display("FAIL reset_async: valid=%b ready=%b busy=%b terr=%b grant=%0d rd=%h insn=%h rs1=%h, required all 0",
               m_valid, req_ready, req_busy, timeout_err, grant_id, req_rd, m_insn, m_rs1);
    end
    set_req(0, 1'b0, '0, '0, '0);
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b0;
    lat = 3;
    @(negedge clk);
    set_req(0, 1'b1, mk(7'h01, 3'd3), 32'hFFFF_FFFF, 32'd2);
    exp_q.push_back('{0, 1'b1, 32'd1});
    wait_resp(20, got);
    set_req(0, 1'b0, '0, '0, '0);
    e = exp_q.pop_front();
    n_vec++;
    if (!got || req_ready !== onehot(e.idx) || req_wr !== onehot(e.idx) || req_rd !== e.rd) begin
      n_err++;
      $display("FAIL reset_mulhu: got=%b ready=%b wr=%b rd=%h, required ready=%b rd=%h",
               got, req_ready, req_wr, req_rd, onehot(e.idx), e.rd);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] a[4], b[4];
    logic [31:0] p_rs1, p_rs2, p_insn;
    bit p_valid;
    int served, zero_run;
    for (int i = 0; i < 4; i++) begin
      a[i] = $urandom_range(1, 60000);
      b[i] = $urandom_range(1, 60000);
    end
    lat = 2;
    served = 0; zero_run = 0; p_valid = 1'b0;
    p_rs1 = '0; p_rs2 = '0; p_insn = '0;
    set_req(0, 1'b1, mk(7'h01, 3'd0), a[0], b[0]);
    exp_q.push_back('{0, 1'b1, a[0] * b[0]});
    for (int c = 0; c < 200 && served < 4; c++) begin
      @(negedge clk);
      if (m_valid && p_valid) begin
        n_vec++;
        if (m_rs1 !== p_rs1 || m_rs2 !== p_rs2 || m_insn !== p_insn) begin
          n_err++;
          $display("FAIL b2b_stable: rs1=%h rs2=%h, required %h %h", m_rs1, m_rs2, p_rs1, p_rs2);
        end
      end
      if (m_valid && !p_valid && served > 0) begin
        n_vec++;
        if (zero_run != 1) begin
          n_err++; $display("FAIL b2b_gap: gap=%0d cycles, required 1", zero_run);
        end
      end
      zero_run = m_valid ? 0 : zero_run + 1;
      if (req_ready == '0 && req_rd !== '0) begin
        n_vec++; n_err++;
        $display("FAIL b2b_rd_idle: rd=%h without ready, required 0", req_rd);
      end
      if (req_ready != '0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (req_ready !== onehot(e.idx) || req_wr !== onehot(e.idx) || req_rd !== e.rd) begin
          n_err++;
          $display("FAIL b2b_resp%0d: ready=%b wr=%b rd=%h, required ready=%b rd=%h",
                   served, req_ready, req_wr, req_rd, onehot(e.idx), e.rd);
        end
        served++;
        if (served < 4) begin
          set_req(0, 1'b1, mk(7'h01, 3'd0), a[served], b[served]);
          exp_q.push_back('{0, 1'b1, a[served] * b[served]});
        end else begin
          set_req(0, 1'b0, '0, '0, '0);
        end
      end
      p_valid = m_valid; p_rs1 = m_rs1; p_rs2 = m_rs2; p_insn = m_insn;
    end
    n_vec++;
    if (served != 4) begin
      n_err++; $display("FAIL b2b_count: served=%0d, required 4", served);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_round_robin();
    test_filter();
    test_timeout();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
